// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Brief    : 2-stage valid/ready fixed-point ALU (8 ops) with accumulator and
//            overflow flag. Define ALU_PIPE_SATURATE_EN to clamp results.
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe #(
  parameter int LEN        = 16,
  parameter int SELECT_LEN = 3,
  parameter int FRAC_BITS  = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LEN-1:0]        in1,
  input  logic [LEN-1:0]        in2,
  input  logic [LEN-1:0]        in3,
  input  logic [SELECT_LEN-1:0] select,
  input  logic                  acc_clear,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LEN-1:0]        out,
  output logic                  overflow
);

  localparam int c_wx = 2*LEN + 2;
  localparam logic signed [c_wx-1:0] c_max = {{(c_wx-LEN+1){1'b0}}, {(LEN-1){1'b1}}};
  localparam logic signed [c_wx-1:0] c_min = {{(c_wx-LEN+1){1'b1}}, {(LEN-1){1'b0}}};

  localparam logic [SELECT_LEN-1:0] c_op_add = SELECT_LEN'(0);
  localparam logic [SELECT_LEN-1:0] c_op_sub = SELECT_LEN'(1);
  localparam logic [SELECT_LEN-1:0] c_op_mul = SELECT_LEN'(2);
  localparam logic [SELECT_LEN-1:0] c_op_mac = SELECT_LEN'(3);
  localparam logic [SELECT_LEN-1:0] c_op_acc = SELECT_LEN'(4);
  localparam logic [SELECT_LEN-1:0] c_op_max = SELECT_LEN'(5);
  localparam logic [SELECT_LEN-1:0] c_op_lt  = SELECT_LEN'(6);

  logic signed [LEN-1:0]   w_a;
  logic signed [LEN-1:0]   w_b;
  logic signed [LEN:0]     w_sum;
  logic signed [2*LEN-1:0] w_prod;
  logic                    w_lt;
  logic [LEN-1:0]          w_pick;
  logic                    w_advance;

  logic                    r_s1_valid;
  logic                    r_s1_lt;
  logic                    r_s1_clr;
  logic [SELECT_LEN-1:0]   r_s1_op;
  logic signed [LEN:0]     r_s1_sum;
  logic signed [2*LEN-1:0] r_s1_prod;
  logic signed [LEN-1:0]   r_s1_pick;
  logic signed [LEN-1:0]   r_s1_c;

  logic signed [LEN-1:0]   r_acc;
  logic                    r_out_valid;
  logic [LEN-1:0]          r_out;
  logic                    r_ovf;

  logic signed [LEN-1:0]   w_acc_base;
  logic signed [c_wx-1:0]  w_exact;
  logic                    w_arith;
  logic                    w_ovf;
  logic [LEN-1:0]          w_res;

  assign w_a       = in1;
  assign w_b       = in2;
  assign w_advance = !r_out_valid || out_ready;
  assign in_ready  = w_advance;
  assign w_lt      = w_a < w_b;
  assign w_prod    = (w_a * w_b) >>> FRAC_BITS;

  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign overflow  = r_ovf;

  // Stage 1 operand math: full-precision sum/diff, scaled product, compare.
  always_comb begin
    w_sum = {w_a[LEN-1], w_a} + {w_b[LEN-1], w_b};
    if (select == c_op_sub) begin
      w_sum = {w_a[LEN-1], w_a} - {w_b[LEN-1], w_b};
    end
    w_pick = in1;
    if ((select == c_op_max) && w_lt) begin
      w_pick = in2;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_lt    <= 1'b0;
      r_s1_clr   <= 1'b0;
      r_s1_op    <= '0;
      r_s1_sum   <= '0;
      r_s1_prod  <= '0;
      r_s1_pick  <= '0;
      r_s1_c     <= '0;
    end else if (w_advance) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_lt   <= w_lt;
        r_s1_clr  <= acc_clear;
        r_s1_op   <= select;
        r_s1_sum  <= w_sum;
        r_s1_prod <= w_prod;
        r_s1_pick <= w_pick;
        r_s1_c    <= in3;
      end
    end
  end

  // Stage 2: accumulator is read here, so back-to-back ACC ops chain without forwarding.
  always_comb begin
    w_acc_base = r_s1_clr ? '0 : r_acc;
    w_arith    = 1'b1;
    w_exact    = '0;
    case (r_s1_op)
      c_op_add, c_op_sub: w_exact = {{(c_wx-LEN-1){r_s1_sum[LEN]}}, r_s1_sum};
      c_op_mul: w_exact = {{2{r_s1_prod[2*LEN-1]}}, r_s1_prod};
      c_op_mac: w_exact = {{2{r_s1_prod[2*LEN-1]}}, r_s1_prod}
                        + {{(c_wx-LEN){r_s1_c[LEN-1]}}, r_s1_c};
      c_op_acc: w_exact = {{2{r_s1_prod[2*LEN-1]}}, r_s1_prod}
                        + {{(c_wx-LEN){w_acc_base[LEN-1]}}, w_acc_base};
      c_op_lt: begin
        w_exact = {{(c_wx-1){1'b0}}, r_s1_lt};
        w_arith = 1'b0;
      end
      default: begin
        w_exact = {{(c_wx-LEN){r_s1_pick[LEN-1]}}, r_s1_pick};
        w_arith = 1'b0;
      end
    endcase
    w_ovf = w_arith && ((w_exact > c_max) || (w_exact < c_min));
    w_res = w_exact[LEN-1:0];
`ifdef ALU_PIPE_SATURATE_EN
    if (w_ovf) begin
      w_res = w_exact[c_wx-1] ? c_min[LEN-1:0] : c_max[LEN-1:0];
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_ovf       <= 1'b0;
      r_acc       <= '0;
    end else if (w_advance) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out <= w_res;
        r_ovf <= w_ovf;
        if (r_s1_op == c_op_acc) begin
          r_acc <= w_res;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe
// Brief    : Directed and randomized checks of alu_pipe against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

  typedef struct {
    longint v;
    bit     o;
  } res_t;

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b0;
  logic        in_valid  = 1'b0;
  logic        acc_clear = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] in1 = '0;
  logic [15:0] in2 = '0;
  logic [15:0] in3 = '0;
  logic [2:0]  sel = '0;
  logic        in_ready, out_valid, ovf;
  logic [15:0] out_d;
  logic        in_ready8, out_valid8, ovf8;
  logic [15:0] out8;

  res_t   exp_q[$];
  res_t   got_q[$];
  longint m_acc = 0;
  int     n_checks = 0;
  int     n_errors = 0;

  always #5 clk = ~clk;

  alu_pipe #(.LEN(16), .SELECT_LEN(3), .FRAC_BITS(0)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .in3(in3), .select(sel), .acc_clear(acc_clear),
    .out_valid(out_valid), .out_ready(out_ready), .out(out_d), .overflow(ovf)
  );

  alu_pipe #(.LEN(16), .SELECT_LEN(3), .FRAC_BITS(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready8),
    .in1(in1), .in2(in2), .in3(in3), .select(sel), .acc_clear(acc_clear),
    .out_valid(out_valid8), .out_ready(out_ready), .out(out8), .overflow(ovf8)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Exact-integer model of one operation (FRAC_BITS = 0 instance).
  function automatic res_t model(input int op, input longint a, input longint b,
                                 input longint c, input bit clr);
    longint      ex;
    bit          arith;
    logic [15:0] lo;
    res_t        r;
    arith = 1'b1;
    case (op)
      0: ex = a + b;
      1: ex = a - b;
      2: ex = a * b;
      3: ex = a * b + c;
      4: ex = (clr ? 0 : m_acc) + a * b;
      5: begin ex = (a > b) ? a : b; arith = 1'b0; end
      6: begin ex = (a < b) ? 1 : 0; arith = 1'b0; end
      default: begin ex = a; arith = 1'b0; end
    endcase
    r.o = arith && (ex > 32767 || ex < -32768);
    lo  = ex[15:0];
    r.v = longint'($signed(lo));
`ifdef ALU_PIPE_SATURATE_EN
    if (r.o) r.v = (ex > 0) ? 32767 : -32768;
`endif
    if (op == 4) m_acc = r.v;
    return r;
  endfunction

  // Scoreboard: deliveries pop the oldest expectation, acceptances push a new one.
  always @(negedge clk) begin
    res_t e;
    if (!reset_n) begin
      exp_q.delete();
      m_acc = 0;
    end else begin
      if (out_valid && out_ready) begin
        e.v = $signed(out_d);
        e.o = ovf;
        got_q.push_back(e);
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out", $signed(out_d), e.v);
          check("ovf", ovf, e.o);
        end
      end
      if (in_valid && in_ready) begin
        e = model(int'(sel), $signed(in1), $signed(in2), $signed(in3), acc_clear);
        exp_q.push_back(e);
      end
    end
  end

  task automatic send(input int op, input int a, input int b, input int c = 0,
                      input bit clr = 1'b0);
    int t;
    in_valid  = 1'b1;
    sel       = 3'(op);
    in1       = 16'(a);
    in2       = 16'(b);
    in3       = 16'(c);
    acc_clear = clr;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("accept_timeout", t, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in1      = 16'($urandom);
    in2      = 16'($urandom);
    sel      = 3'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic expect_got(input string tag, input int idx, input longint v, input bit o);
    check(tag, got_q[idx].v, v);
    check({tag, "_ovf"}, got_q[idx].o, o);
  endtask

  function automatic logic [15:0] rnd();
    logic [15:0] ext [4];
    ext = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001};
    case ($urandom_range(0, 3))
      0: return 16'($urandom_range(0, 20)) - 16'd10;
      1: return ext[$urandom_range(0, 3)];
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    longint sat_exp;
`ifdef ALU_PIPE_SATURATE_EN
    sat_exp = 32767;
`else
    sat_exp = -32768;
`endif
    // reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out_d, 0);
    check("rst_ovf", ovf, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // ADD then SUB back-to-back: 188 two edges after presentation, 64 next cycle
    send(0, 100, 88);
    send(1, 32, -32);
    @(negedge clk);
    check("t1_valid_a", out_valid, 1);
    check("t1_add", $signed(out_d), 188);
    check("t1_add_ovf", ovf, 0);
    @(negedge clk);
    check("t1_valid_b", out_valid, 1);
    check("t1_sub", $signed(out_d), 64);
    @(posedge clk); #1;
    drain();

    // MAC / MAX / LT, then MUL on the FRAC_BITS=8 instance
    got_q.delete();
    send(3, -21, -121, -11);
    send(5, -5, 3);
    send(6, -5, 3);
    drain();
    expect_got("t2_mac", 0, 2530, 0);
    expect_got("t2_max", 1, 3, 0);
    expect_got("t2_lt", 2, 1, 0);
    send(2, 256, 256);
    send(2, -256, 256);
    @(negedge clk);
    check("t2_f8_valid", out_valid8, 1);
    check("t2_f8_mul", $signed(out8), 256);
    check("t2_f8_ovf", ovf8, 0);
    check("t2_f8_ready", in_ready8, 1);
    @(negedge clk);
    check("t2_f8_mul_neg", $signed(out8), -256);
    @(posedge clk); #1;
    drain();

    // overflow at the positive boundary
    got_q.delete();
    send(0, 32767, 1);
    drain();
    expect_got("t3_add_ovf", 0, sat_exp, 1);

    // accumulator chain and clear
    got_q.delete();
    send(4, 2, 3, 0, 1);
    send(4, 4, 5, 0, 0);
    send(4, 1, 1, 0, 0);
    send(4, 7, 1, 0, 1);
    drain();
    expect_got("t4_acc0", 0, 6, 0);
    expect_got("t4_acc1", 1, 26, 0);
    expect_got("t4_acc2", 2, 27, 0);
    expect_got("t4_acc3", 3, 7, 0);

    // backpressure: two accepted, then stall holding the first result
    got_q.delete();
    out_ready = 1'b0;
    send(0, 1, 1);
    send(0, 2, 2);
    in_valid = 1'b1; sel = 3'd0; in1 = 16'd3; in2 = 16'd3;
    repeat (3) begin
      @(negedge clk);
      check("t5_in_ready_low", in_ready, 0);
      check("t5_out_valid", out_valid, 1);
      check("t5_out_held", $signed(out_d), 2);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(0, 3, 3);
    send(0, 4, 4);
    drain();
    check("t5_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++) expect_got("t5_order", i, 2 * (i + 1), 0);

    // reset with ops in flight and acc=27
    send(4, 2, 3, 0, 1);
    send(4, 4, 5, 0, 0);
    send(4, 1, 1, 0, 0);
    drain();
    send(0, 5, 5);
    send(0, 6, 6);
    reset_n = 1'b0;
    #1;
    check("t6_valid", out_valid, 0);
    check("t6_out", out_d, 0);
    check("t6_ovf", ovf, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("t6_no_pulse", out_valid, 0);
    @(posedge clk); #1;
    got_q.delete();
    send(4, 1, 1, 0, 0);
    drain();
    check("t6_count", got_q.size(), 1);
    expect_got("t6_acc", 0, 1, 0);

    // randomized traffic with random backpressure and bubbles
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      sel       = 3'($urandom_range(0, 7));
      in1       = rnd();
      in2       = rnd();
      in3       = rnd();
      acc_clear = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
